// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared widths, controller state encoding and line word
// helpers for the direct-mapped write-through cache controller.
//   Address split (word address): tag [15:4], index [3:2], offset [1:0].
//   A line is four 16-bit words packed word0 in [15:0] .. word3 in [63:48].
package cache_ctrl_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int CACHE_TAG_W = 12;
  localparam int CACHE_IDX_W = 2;
  localparam int CACHE_OFF_W = 2;
  localparam int CACHE_LINES = 1 << CACHE_IDX_W;
  localparam int LINE_W      = WORD_SIZE << CACHE_OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } cache_state_t;

  // Select one word out of a line.
  function automatic logic [WORD_SIZE-1:0] line_word(
    input logic [LINE_W-1:0]      line,
    input logic [CACHE_OFF_W-1:0] off
  );
    logic [WORD_SIZE-1:0] w;
    case (off)
      2'd0:    w = line[15:0];
      2'd1:    w = line[31:16];
      2'd2:    w = line[47:32];
      default: w = line[63:48];
    endcase
    return w;
  endfunction

  // Return a copy of the line with one word replaced.
  function automatic logic [LINE_W-1:0] line_put(
    input logic [LINE_W-1:0]      line,
    input logic [CACHE_OFF_W-1:0] off,
    input logic [WORD_SIZE-1:0]   w
  );
    logic [LINE_W-1:0] l;
    l = line;
    case (off)
      2'd0:    l[15:0]  = w;
      2'd1:    l[31:16] = w;
      2'd2:    l[47:32] = w;
      default: l[63:48] = w;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: line-wide memory port between one cache instance and the
// shared memory arbiter.
//   mem_req   cache -> arbiter  request, held until mem_ack
//   mem_we    cache -> arbiter  1 = single-word write, 0 = line read
//   mem_addr  cache -> arbiter  word address (line reads use offset 00)
//   mem_wdata cache -> arbiter  store data
//   mem_rdata arbiter -> cache  fill line, word0 in [15:0]
//   mem_ack   arbiter -> cache  one-cycle completion pulse
// Handshake: the cache raises mem_req together with mem_we/mem_addr/mem_wdata
// and holds all four unchanged while mem_ack is 0. A transfer completes on
// the single clock edge where mem_req and mem_ack are both 1; mem_rdata is
// only meaningful on that edge of a line read. mem_ack seen while mem_req is
// 0 carries no meaning and is ignored.
interface cache_ctrl_if;
  import cache_ctrl_pkg::*;

  logic                 mem_req;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [LINE_W-1:0]    mem_rdata;
  logic                 mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_ctrl_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones.
//   clk, reset_n  clock, asynchronous active-low reset (clears to 0)
//   en            count this cycle
//   count         current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache
// controller (4 lines x 4 words). Responder for the pipeline's cache port.
//   clk, reset_n            clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata   pipeline access (held stable while stalled)
//   cpu_rdata               load data
//   hit                     combinational: load hit, or no request pending
//   ready                   one-cycle pulse when a fill or store completes
//   both_access             I- and D-side both outstanding (statistics only)
//   mem                     line-wide memory port (master side)
//   hit/miss/contend_count  saturating access statistics
//   dbg_state               controller state for observation
module cache_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 hit,
  output logic                 ready,
  input  logic                 both_access,
  cache_ctrl_if.master         mem,
  output logic [WORD_SIZE-1:0] hit_count,
  output logic [WORD_SIZE-1:0] miss_count,
  output logic [WORD_SIZE-1:0] contend_count,
  output cache_state_t         dbg_state
);

  // Storage
  logic [CACHE_LINES-1:0] valid_q;
  logic [CACHE_TAG_W-1:0] tag_q  [CACHE_LINES];
  logic [LINE_W-1:0]      data_q [CACHE_LINES];

  // Controller registers
  cache_state_t           state_q;
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [WORD_SIZE-1:0]   mem_addr_q;
  logic [WORD_SIZE-1:0]   mem_wdata_q;
  logic                   ready_q;
  logic [CACHE_OFF_W-1:0] off_q;   // requested word of an outstanding load
  logic                   load_q;  // outstanding transaction is a load

  // Request decode
  logic [CACHE_TAG_W-1:0] cpu_tag;
  logic [CACHE_IDX_W-1:0] cpu_idx;
  logic [CACHE_OFF_W-1:0] cpu_off;
  logic                   lookup_match;
  logic                   load_hit;
  logic                   accept;

  // The in-flight transaction is identified by the latched memory address,
  // so it completes correctly even if the pipeline drops or changes cpu_*.
  logic [CACHE_TAG_W-1:0] txn_tag;
  logic [CACHE_IDX_W-1:0] txn_idx;
  logic [CACHE_OFF_W-1:0] txn_off;

  assign cpu_tag = cpu_addr[15:4];
  assign cpu_idx = cpu_addr[3:2];
  assign cpu_off = cpu_addr[1:0];
  assign txn_tag = mem_addr_q[15:4];
  assign txn_idx = mem_addr_q[3:2];
  assign txn_off = mem_addr_q[1:0];

  assign lookup_match = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign load_hit     = (state_q == ST_IDLE) && cpu_req && !cpu_we && lookup_match;
  assign accept       = (state_q == ST_IDLE) && cpu_req;

  // An idle port reports hit so the pipeline never stalls on it.
  assign hit   = load_hit || !cpu_req;
  assign ready = ready_q;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign dbg_state     = state_q;

  // In DONE after a fill the word comes from the latched address, so the
  // filled word is returned even if cpu_addr has moved on.
  always_comb begin
    cpu_rdata = '0;
    if ((state_q == ST_DONE) && load_q) begin
      cpu_rdata = line_word(data_q[txn_idx], off_q);
    end else if (lookup_match) begin
      cpu_rdata = line_word(data_q[cpu_idx], cpu_off);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ready_q     <= 1'b0;
      off_q       <= '0;
      load_q      <= 1'b0;
      valid_q     <= '0;
      for (int i = 0; i < CACHE_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (cpu_req) begin
            if (cpu_we) begin
              state_q     <= ST_WRITE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= cpu_addr;
              mem_wdata_q <= cpu_wdata;
              load_q      <= 1'b0;
            end else if (!lookup_match) begin
              state_q    <= ST_FILL;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {cpu_addr[15:2], 2'b00};
              off_q      <= cpu_off;
              load_q     <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (mem.mem_ack) begin
            data_q[txn_idx]  <= mem.mem_rdata;
            tag_q[txn_idx]   <= txn_tag;
            valid_q[txn_idx] <= 1'b1;
            mem_req_q        <= 1'b0;
            ready_q          <= 1'b1;
            state_q          <= ST_DONE;
          end
        end
        ST_WRITE: begin
          if (mem.mem_ack) begin
            // Write-through: only a resident line is updated; a miss leaves
            // the cache untouched (no allocate).
            if (valid_q[txn_idx] && (tag_q[txn_idx] == txn_tag)) begin
              data_q[txn_idx] <= line_put(data_q[txn_idx], txn_off, mem_wdata_q);
            end
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Statistics, counted on the IDLE cycle an access is accepted.
  logic hit_inc;
  logic miss_inc;
  logic contend_inc;

  assign hit_inc     = load_hit;
  assign miss_inc    = accept && !load_hit;
  assign contend_inc = miss_inc && both_access;

  sat_counter #(.W(WORD_SIZE)) u_hit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (hit_inc),
    .count   (hit_count)
  );

  sat_counter #(.W(WORD_SIZE)) u_miss_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (miss_inc),
    .count   (miss_count)
  );

  sat_counter #(.W(WORD_SIZE)) u_contend_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (contend_inc),
    .count   (contend_count)
  );

endmodule
